riscv_prefetch_ctrl: RTL and testbench
======================================

RISCV_PREFETCH_CTRL -- requirements
Module: riscv_prefetch_ctrl

Interface
REQ-001 SHALL have parameter RDATA_WIDTH, default 32, width of instruction fetch word.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 SHALL have port clk  in  1  clock, all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  synchronous active-high reset.
REQ-005 SHALL have port req_i  in  1  fetching enabled.
REQ-006 SHALL have port branch_i  in  1  redirect fetch stream, single-cycle pulse.
REQ-007 SHALL have port branch_addr_i  in  32  redirect target, halfword aligned.
REQ-008 SHALL have port instr_req_o  out  1  memory request.
REQ-009 SHALL have port instr_addr_o  out  32  memory word address, bits[1:0]=00.
REQ-010 SHALL have port instr_gnt_i  in  1  request accepted.
REQ-011 SHALL have port instr_rvalid_i  in  1  response data valid.
REQ-012 SHALL have port instr_rdata_i  in  RDATA_WIDTH  response data.
REQ-013 SHALL have port fifo_valid_o  out  1  word pushed into fetch FIFO.
REQ-014 SHALL have port fifo_addr_o  out  32  address of pushed word.
REQ-015 SHALL have port fifo_rdata_o  out  RDATA_WIDTH  pushed word.
REQ-016 SHALL have port fifo_ready_i  in  1  FIFO can accept a word.
REQ-017 SHALL have port fifo_clear_o  out  1  flush FIFO.
REQ-018 SHALL have port busy_o  out  1  request outstanding.

Function
REQ-019 SHALL implement states IDLE, WAIT_GNT, WAIT_RVALID, WAIT_ABORTED; at most one request outstanding.
REQ-020 SHALL hold fetch_addr_q (32b); issue address = branch_i ? {branch_addr_i[31:2],00} : {fetch_addr_q[31:2],00}.
REQ-021 IDLE: instr_req_o = (req_i & fifo_ready_i) | branch_i; gnt -> WAIT_RVALID, no gnt -> WAIT_GNT.
REQ-022 WAIT_GNT: instr_req_o held 1 and instr_addr_o held stable regardless of req_i/fifo_ready_i; gnt -> WAIT_RVALID.
REQ-023 branch_i in WAIT_GNT: request unchanged; fetch_addr_q <- branch_addr_i; gnt -> WAIT_ABORTED.
REQ-024 On grant of a non-aborted request: issued_addr_q <- issue address with bit[1] from fetch_addr_q (or branch_addr_i); fetch_addr_q <- aligned issue address + 4, modulo 2^32.
REQ-025 WAIT_RVALID with rvalid: fifo_valid_o=1, fifo_rdata_o=instr_rdata_i, fifo_addr_o=issued_addr_q, same cycle; next request may issue same cycle per REQ-021 rules (back-to-back), else -> IDLE.
REQ-026 fifo_valid_o SHALL be 0 in every other case; fifo_addr_o/fifo_rdata_o don't-care when 0.
REQ-027 branch_i in WAIT_RVALID without rvalid: -> WAIT_ABORTED, fetch_addr_q <- branch_addr_i, no new request.
REQ-028 branch_i coincident with rvalid: response dropped (fifo_valid_o=0); request to branch target issued same cycle.
REQ-029 WAIT_ABORTED: rvalid dropped; on rvalid issue request to fetch_addr_q if req_i & fifo_ready_i (or branch_i), else -> IDLE; further branch_i updates fetch_addr_q, stays WAIT_ABORTED.
REQ-030 fifo_clear_o = branch_i, combinational, every state.
REQ-031 busy_o = (state != IDLE).
REQ-032 fifo_ready_i low SHALL block only new issue, never an in-flight response; upstream FIFO guarantees space for one outstanding word.
REQ-033 Unaligned target: fifo_addr_o bit[1] preserved for first word only; subsequent words bit[1]=0.

Reset
REQ-034 rst SHALL override all inputs: state IDLE, fetch_addr_q=0, issued_addr_q=0.
REQ-035 During rst, instr_req_o=0, fifo_valid_o=0, fifo_clear_o=0, busy_o=0; instr_addr_o=0, fifo_addr_o=0, fifo_rdata_o=0.
REQ-036 rst mid-transaction abandons outstanding request; a response after rst deassertion in IDLE SHALL be ignored.

Verification
REQ-037 branch 0x100, gnt immediate, rvalid next cycle, req_i held -> req addr 0x100; push addr 0x100; back-to-back req 0x104.
REQ-038 gnt delayed 3 cycles, req_i dropped meanwhile -> instr_req_o and addr 0x100 stable all 3 cycles.
REQ-039 branch 0x200 while WAIT_RVALID, rvalid next cycle -> no push; fifo_clear_o pulse; then request 0x200.
REQ-040 branch 0x302 -> request 0x300; push addr 0x302; next request 0x304, push addr 0x304.
REQ-041 fetch_addr 0xFFFFFFFC granted -> next request address 0x00000000.
REQ-042 fifo_ready_i=0 in IDLE with req_i=1 -> no request; rst asserted in WAIT_RVALID -> IDLE, late rvalid produces no push.

Source files
------------

// File: rtl/riscv_prefetch_ctrl.sv
// Instruction prefetch controller: issues one word fetch at a time to instruction
// memory, forwards responses to the fetch FIFO and redirects the stream on branches.
module riscv_prefetch_ctrl #(
    parameter int RDATA_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_i,
    input  logic                   branch_i,
    input  logic [31:0]            branch_addr_i,
    output logic                   instr_req_o,
    output logic [31:0]            instr_addr_o,
    input  logic                   instr_gnt_i,
    input  logic                   instr_rvalid_i,
    input  logic [RDATA_WIDTH-1:0] instr_rdata_i,
    output logic                   fifo_valid_o,
    output logic [31:0]            fifo_addr_o,
    output logic [RDATA_WIDTH-1:0] fifo_rdata_o,
    input  logic                   fifo_ready_i,
    output logic                   fifo_clear_o,
    output logic                   busy_o,
    output logic [1:0]             dbg_state_o
);

    // Memory handshake: a request is accepted in the cycle instr_req_o and
    // instr_gnt_i are both high; once requested, instr_req_o and instr_addr_o
    // stay fixed until that grant. Exactly one instr_rvalid_i follows each grant.
    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] WAIT_GNT     = 2'd1;
    localparam logic [1:0] WAIT_RVALID  = 2'd2;
    localparam logic [1:0] WAIT_ABORTED = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_fetch_addr;
    logic [31:0] r_issued_addr;
    logic [31:0] r_req_addr;
    logic        r_abort;

    logic [31:0] w_issue_src;
    logic [31:0] w_issue_addr;
    logic [31:0] w_issue_hw;
    logic        w_want_issue;
    logic        w_issue_slot;
    logic        w_issue;
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_push;

    always_comb begin
        w_issue_src  = branch_i ? branch_addr_i : r_fetch_addr;
        w_issue_addr = {w_issue_src[31:2], 2'b00};
        w_issue_hw   = {w_issue_src[31:1], 1'b0};
        w_want_issue = (req_i & fifo_ready_i) | branch_i;
        // A new request may go out from IDLE, or in the cycle the pending response lands.
        w_issue_slot = (r_state == IDLE) |
                       (((r_state == WAIT_RVALID) | (r_state == WAIT_ABORTED)) & instr_rvalid_i);
        w_issue      = w_issue_slot & w_want_issue;
        w_req        = (r_state == WAIT_GNT) | w_issue;
        w_addr       = (r_state == WAIT_GNT) ? {r_req_addr[31:2], 2'b00} : w_issue_addr;
        w_push       = (r_state == WAIT_RVALID) & instr_rvalid_i & ~branch_i;
    end

    assign instr_req_o  = ~rst & w_req;
    assign instr_addr_o = rst ? 32'd0 : w_addr;
    assign fifo_valid_o = ~rst & w_push;
    assign fifo_addr_o  = (~rst & w_push) ? r_issued_addr : 32'd0;
    assign fifo_rdata_o = (~rst & w_push) ? instr_rdata_i : '0;
    assign fifo_clear_o = ~rst & branch_i;
    assign busy_o       = ~rst & (r_state != IDLE);
    assign dbg_state_o  = rst ? IDLE : r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_fetch_addr  <= 32'd0;
            r_issued_addr <= 32'd0;
            r_req_addr    <= 32'd0;
            r_abort       <= 1'b0;
        end else if (r_state == WAIT_GNT) begin
            // A branch here cannot retract the request; its response is discarded later.
            if (branch_i) begin
                r_fetch_addr <= branch_addr_i;
                r_abort      <= 1'b1;
            end
            if (instr_gnt_i) begin
                if (r_abort | branch_i) begin
                    r_state <= WAIT_ABORTED;
                end else begin
                    r_state       <= WAIT_RVALID;
                    r_issued_addr <= r_req_addr;
                    r_fetch_addr  <= {r_req_addr[31:2], 2'b00} + 32'd4;
                end
            end
        end else if (w_issue) begin
            if (instr_gnt_i) begin
                r_state       <= WAIT_RVALID;
                r_issued_addr <= w_issue_hw;
                r_fetch_addr  <= w_issue_addr + 32'd4;
            end else begin
                r_state    <= WAIT_GNT;
                r_req_addr <= w_issue_hw;
                r_abort    <= 1'b0;
            end
        end else if (w_issue_slot) begin
            r_state <= IDLE;
        end else if (branch_i) begin
            r_state      <= WAIT_ABORTED;
            r_fetch_addr <= branch_addr_i;
        end
    end

endmodule

// File: tb/tb_riscv_prefetch_ctrl.sv
// Directed bench for riscv_prefetch_ctrl: a per-cycle vector table followed by
// hand-written delayed-grant sequences.
module tb_riscv_prefetch_ctrl;

    logic        clk;
    logic        rst;
    logic        req_i;
    logic        branch_i;
    logic [31:0] branch_addr_i;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        fifo_valid_o;
    logic [31:0] fifo_addr_o;
    logic [31:0] fifo_rdata_o;
    logic        fifo_ready_i;
    logic        fifo_clear_o;
    logic        busy_o;
    logic [1:0]  dbg_state_o;

    riscv_prefetch_ctrl #(.RDATA_WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_i          (req_i),
        .branch_i       (branch_i),
        .branch_addr_i  (branch_addr_i),
        .instr_req_o    (instr_req_o),
        .instr_addr_o   (instr_addr_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .fifo_valid_o   (fifo_valid_o),
        .fifo_addr_o    (fifo_addr_o),
        .fifo_rdata_o   (fifo_rdata_o),
        .fifo_ready_i   (fifo_ready_i),
        .fifo_clear_o   (fifo_clear_o),
        .busy_o         (busy_o),
        .dbg_state_o    (dbg_state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        req;
        logic        rdy;
        logic        br;
        logic [31:0] baddr;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_fv;
        logic [31:0] e_faddr;
        logic        e_clr;
        logic        e_busy;
    } vec_t;

    localparam int NVEC = 28;
    vec_t        vecs[NVEC];
    int          n_checks;
    int          n_fail;
    logic [31:0] ta;
    logic        got;

    function automatic vec_t mk(logic rst_v, logic req_v, logic rdy_v, logic br_v,
                                logic [31:0] baddr_v, logic gnt_v, logic rv_v,
                                logic [31:0] rdata_v, logic ereq_v, logic [31:0] eaddr_v,
                                logic efv_v, logic [31:0] efaddr_v, logic eclr_v,
                                logic ebusy_v);
        vec_t v;
        v.rst = rst_v;   v.req = req_v;     v.rdy = rdy_v;     v.br = br_v;
        v.baddr = baddr_v; v.gnt = gnt_v;   v.rv = rv_v;       v.rdata = rdata_v;
        v.e_req = ereq_v; v.e_addr = eaddr_v; v.e_fv = efv_v;  v.e_faddr = efaddr_v;
        v.e_clr = eclr_v; v.e_busy = ebusy_v;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst_v, input logic req_v, input logic rdy_v,
                         input logic br_v, input logic [31:0] baddr_v, input logic gnt_v,
                         input logic rv_v, input logic [31:0] rdata_v);
        rst            = rst_v;
        req_i          = req_v;
        fifo_ready_i   = rdy_v;
        branch_i       = br_v;
        branch_addr_i  = baddr_v;
        instr_gnt_i    = gnt_v;
        instr_rvalid_i = rv_v;
        instr_rdata_i  = rdata_v;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // rst req rdy br baddr gnt rv rdata | e_req e_addr e_fv e_faddr e_clr e_busy
        vecs[0]  = mk(1,1,1,1,32'h100,1,1,32'hDEADBEEF,        0,32'h0,0,32'h0,0,0);
        vecs[1]  = mk(1,0,1,0,32'h0,0,0,32'h0,                 0,32'h0,0,32'h0,0,0);
        vecs[2]  = mk(0,1,1,1,32'h100,1,0,32'h0,               1,32'h100,0,32'h0,1,0);
        vecs[3]  = mk(0,1,1,0,32'h0,1,1,32'h11111111,          1,32'h104,1,32'h100,0,1);
        vecs[4]  = mk(0,1,1,0,32'h0,0,1,32'h22222222,          1,32'h108,1,32'h104,0,1);
        vecs[5]  = mk(0,0,1,0,32'h0,0,0,32'h0,                 1,32'h108,0,32'h0,0,1);
        vecs[6]  = mk(0,0,0,0,32'h0,0,0,32'h0,                 1,32'h108,0,32'h0,0,1);
        vecs[7]  = mk(0,0,1,0,32'h0,1,0,32'h0,                 1,32'h108,0,32'h0,0,1);
        vecs[8]  = mk(0,0,1,0,32'h0,0,1,32'h33333333,          0,32'h0,1,32'h108,0,1);
        vecs[9]  = mk(0,0,1,0,32'h0,0,0,32'h0,                 0,32'h0,0,32'h0,0,0);
        vecs[10] = mk(0,1,0,0,32'h0,1,0,32'h0,                 0,32'h0,0,32'h0,0,0);
        vecs[11] = mk(0,1,1,0,32'h0,1,0,32'h0,                 1,32'h10C,0,32'h0,0,0);
        vecs[12] = mk(0,1,1,1,32'h200,0,0,32'h0,               0,32'h0,0,32'h0,1,1);
        vecs[13] = mk(0,1,1,0,32'h0,1,1,32'h44444444,          1,32'h200,0,32'h0,0,1);
        vecs[14] = mk(0,0,1,0,32'h0,0,1,32'h55555555,          0,32'h0,1,32'h200,0,1);
        vecs[15] = mk(0,1,1,0,32'h0,1,0,32'h0,                 1,32'h204,0,32'h0,0,0);
        vecs[16] = mk(0,1,1,1,32'h302,1,1,32'h5A5A5A5A,        1,32'h300,0,32'h0,1,1);
        vecs[17] = mk(0,1,1,0,32'h0,1,1,32'h66666666,          1,32'h304,1,32'h302,0,1);
        vecs[18] = mk(0,0,1,0,32'h0,0,1,32'h77777777,          0,32'h0,1,32'h304,0,1);
        vecs[19] = mk(0,1,1,1,32'hFFFFFFFC,1,0,32'h0,          1,32'hFFFFFFFC,0,32'h0,1,0);
        vecs[20] = mk(0,1,1,0,32'h0,0,1,32'h88888888,          1,32'h0,1,32'hFFFFFFFC,0,1);
        vecs[21] = mk(0,0,1,1,32'h400,0,0,32'h0,               1,32'h0,0,32'h0,1,1);
        vecs[22] = mk(0,0,1,0,32'h0,1,0,32'h0,                 1,32'h0,0,32'h0,0,1);
        vecs[23] = mk(0,1,1,0,32'h0,1,1,32'h99999999,          1,32'h400,0,32'h0,0,1);
        vecs[24] = mk(1,1,1,0,32'h0,1,1,32'hAAAAAAAA,          0,32'h0,0,32'h0,0,0);
        vecs[25] = mk(0,0,1,0,32'h0,0,1,32'hBBBBBBBB,          0,32'h0,0,32'h0,0,0);
        vecs[26] = mk(0,1,1,0,32'h0,1,0,32'h0,                 1,32'h0,0,32'h0,0,0);
        vecs[27] = mk(0,0,1,0,32'h0,0,1,32'hABABABAB,          0,32'h0,1,32'h0,0,1);

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].rst, vecs[i].req, vecs[i].rdy, vecs[i].br, vecs[i].baddr,
                  vecs[i].gnt, vecs[i].rv, vecs[i].rdata);
            @(negedge clk);
            chk1($sformatf("v%0d_req", i), instr_req_o, vecs[i].e_req);
            chk1($sformatf("v%0d_fvalid", i), fifo_valid_o, vecs[i].e_fv);
            chk1($sformatf("v%0d_clear", i), fifo_clear_o, vecs[i].e_clr);
            chk1($sformatf("v%0d_busy", i), busy_o, vecs[i].e_busy);
            if (vecs[i].rst) begin
                chk($sformatf("v%0d_rst_addr", i), instr_addr_o, 32'h0);
                chk($sformatf("v%0d_rst_faddr", i), fifo_addr_o, 32'h0);
                chk($sformatf("v%0d_rst_frdata", i), fifo_rdata_o, 32'h0);
            end else begin
                if (vecs[i].e_req)
                    chk($sformatf("v%0d_addr", i), instr_addr_o, vecs[i].e_addr);
                if (vecs[i].e_fv) begin
                    chk($sformatf("v%0d_faddr", i), fifo_addr_o, vecs[i].e_faddr);
                    chk($sformatf("v%0d_frdata", i), fifo_rdata_o, vecs[i].rdata);
                end
            end
            next_cycle();
        end

        // Delayed grant with req_i and fifo_ready_i dropped: request must hold steady.
        for (int d = 1; d <= 3; d++) begin
            ta = 32'h500 + 32'(d) * 32'h10;
            drive(0, 1, 1, 1, ta, 0, 0, 32'h0);
            @(negedge clk);
            chk1($sformatf("hs%0d_req_first", d), instr_req_o, 1'b1);
            chk($sformatf("hs%0d_addr_first", d), instr_addr_o, ta);
            chk1($sformatf("hs%0d_clear", d), fifo_clear_o, 1'b1);
            next_cycle();
            for (int k = 0; k < d; k++) begin
                drive(0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
                @(negedge clk);
                chk1($sformatf("hs%0d_req_hold%0d", d, k), instr_req_o, 1'b1);
                chk($sformatf("hs%0d_addr_hold%0d", d, k), instr_addr_o, ta);
                chk1($sformatf("hs%0d_busy%0d", d, k), busy_o, 1'b1);
                next_cycle();
            end
            drive(0, 0, 1, 0, 32'h0, 1, 0, 32'h0);
            @(negedge clk);
            chk1($sformatf("hs%0d_req_gnt", d), instr_req_o, 1'b1);
            chk($sformatf("hs%0d_addr_gnt", d), instr_addr_o, ta);
            next_cycle();
            got = 1'b0;
            for (int k = 0; k < 8; k++) begin
                if (!got) begin
                    drive(0, 0, 1, 0, 32'h0, 0, (k == d - 1), 32'hC0DE0000 + 32'(d));
                    @(negedge clk);
                    if (fifo_valid_o) begin
                        got = 1'b1;
                        chk($sformatf("hs%0d_push_addr", d), fifo_addr_o, ta);
                        chk($sformatf("hs%0d_push_data", d), fifo_rdata_o, 32'hC0DE0000 + 32'(d));
                    end
                    next_cycle();
                end
            end
            chk1($sformatf("hs%0d_push_seen", d), got, 1'b1);
            drive(0, 0, 1, 0, 32'h0, 0, 0, 32'h0);
            @(negedge clk);
            chk1($sformatf("hs%0d_idle", d), busy_o, 1'b0);
            next_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
